// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg: shared width constants for the simple processor.
package simple_processor_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port sequencing arbiter for a single-ported data memory.
// Define DMEM_ARB_RR_EN for round-robin contention, otherwise port 0 has fixed priority.
module dmem_arbiter
  import simple_processor_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*DATA_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    busy_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e                state_q;
  logic                  owner_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            cnt_q;
  logic                  win_d;
`ifdef DMEM_ARB_RR_EN
  // rr_q remembers the last served port; reset to 1 so port 0 wins first
  logic rr_q;
  assign win_d = &req_i ? ~rr_q : req_i[1];
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) rr_q <= 1'b1;
    else if (|gnt_o) rr_q <= win_d;
  end
`else
  assign win_d = ~req_i[0];
`endif
  assign gnt_o       = (state_q == IDLE && |req_i) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
  assign rvalid_o    = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o      = state_q != IDLE;
  assign mem_req_o   = state_q == ISSUE;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          owner_q <= win_d;
          we_q    <= we_i[win_d];
          addr_q  <= win_d ? addr_i[2*DATA_WIDTH-1:DATA_WIDTH] : addr_i[DATA_WIDTH-1:0];
          wdata_q <= win_d ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
          state_q <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= 4'(MEM_LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == 4'd0) begin
          if (!we_q) rdata_q <= mem_rdata_i;
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed checks of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  import simple_processor_pkg::*;
  localparam int DW  = DATA_WIDTH;
  localparam int LAT = 2;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic arst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  logic [1:0]      req_i, we_i, gnt_o, rvalid_o;
  logic [2*DW-1:0] addr_i, wdata_i;
  logic [DW-1:0]   rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic            busy_o, mem_req_o, mem_we_o;
  dmem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i));
  logic [1:0]    lreq1, lreq15, lgnt1, lgnt15, lrv1, lrv15;
  logic [DW-1:0] lrd1, lrd15, lma1, lma15, lmw1, lmw15;
  logic          lb1, lb15, lmr1, lmr15, lwe1, lwe15;
  dmem_arbiter #(.MEM_LATENCY(1)) u_lat1 (
    .clk_i(clk_i), .arst_ni(arst_ni), .req_i(lreq1), .we_i(2'b00), .addr_i('0),
    .wdata_i('0), .gnt_o(lgnt1), .rvalid_o(lrv1), .rdata_o(lrd1),
    .busy_o(lb1), .mem_req_o(lmr1), .mem_we_o(lwe1), .mem_addr_o(lma1),
    .mem_wdata_o(lmw1), .mem_rdata_i(32'h1111_0001));
  dmem_arbiter #(.MEM_LATENCY(15)) u_lat15 (
    .clk_i(clk_i), .arst_ni(arst_ni), .req_i(lreq15), .we_i(2'b00), .addr_i('0),
    .wdata_i('0), .gnt_o(lgnt15), .rvalid_o(lrv15), .rdata_o(lrd15),
    .busy_o(lb15), .mem_req_o(lmr15), .mem_we_o(lwe15), .mem_addr_o(lma15),
    .mem_wdata_o(lmw15), .mem_rdata_i(32'h1111_000F));
  int n_vec = 0;
  int n_bad = 0;
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Model: one in-flight transaction described by its grant cycle and latched fields
  bit         act, town, twe, last;
  int         tg, cyc;
  logic [DW-1:0] taddr, twdata, mrdata;
  logic [1:0] eg_last, gnt_seen;
  task automatic model_reset();
    act = 0; town = 0; twe = 0; last = 1;
    taddr = '0; twdata = '0; mrdata = '0;
  endtask
  task automatic step(input logic [1:0] rq, input logic [1:0] w, input logic [2*DW-1:0] a,
                      input logic [2*DW-1:0] wd, input logic [DW-1:0] mrd);
    bit idle, win, rd_upd;
    logic [1:0] eg, erv;
    logic [DW-1:0] rd_next;
    req_i = rq; we_i = w; addr_i = a; wdata_i = wd; mem_rdata_i = mrd;
    #1;
    if (act && cyc >= tg + LAT + 3) act = 0;
    idle = !act;
    win = 0;
    eg = 2'b00;
    if (idle && rq != 2'b00) begin
      if (rq == 2'b11) win = RR ? !last : 1'b0;
      else win = rq[1];
      eg = win ? 2'b10 : 2'b01;
    end
    erv = (act && cyc == tg + LAT + 2) ? (town ? 2'b10 : 2'b01) : 2'b00;
    gnt_seen = gnt_o;
    check_eq("gnt", gnt_o, eg);
    check_eq("rvalid", rvalid_o, erv);
    check_eq("busy", busy_o, !idle);
    check_eq("mem_req", mem_req_o, act && cyc == tg + 1);
    check_eq("mem_we", mem_we_o, twe);
    check_eq("mem_addr", mem_addr_o, taddr);
    check_eq("mem_wdata", mem_wdata_o, twdata);
    check_eq("rdata", rdata_o, mrdata);
    rd_upd = 0;
    rd_next = '0;
    if (act && cyc == tg + LAT + 1 && !twe) begin
      rd_upd = 1;
      rd_next = mrd;
    end
    if (eg != 2'b00) begin
      act = 1; tg = cyc; town = win; last = win; twe = w[win];
      taddr  = win ? a[2*DW-1:DW] : a[DW-1:0];
      twdata = win ? wd[2*DW-1:DW] : wd[DW-1:0];
    end
    eg_last = eg;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rd_upd) mrdata = rd_next;
  endtask
  task automatic idle_steps(input int n);
    repeat (n) step(2'b00, 2'b00, '0, '0, $urandom);
  endtask
  logic [1:0] gq[$];
  logic [1:0] pend, pwe;
  logic [2*DW-1:0] pa, pw;
  int n1, n15;
  bit busy_granted;
  initial begin
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    lreq1 = '0; lreq15 = '0;
    model_reset();
    cyc = 0;
    #12 arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    idle_steps(1);
    // contention straight after reset: port 0 wins first
    for (int i = 0; i < 4 * (LAT + 3); i++) begin
      step(2'b11, 2'b00, {32'h0000_0200, 32'h0000_0100}, '0, $urandom);
      if (eg_last != 2'b00) gq.push_back(gnt_seen);
    end
    check_eq("contention_count", gq.size(), 4);
    for (int k = 0; k < 4 && k < gq.size(); k++)
      check_eq("contention_gnt", gq[k], (RR && k % 2 == 1) ? 2'b10 : 2'b01);
    idle_steps(LAT + 3);
    step(2'b01, 2'b00, {32'h0, 32'h0000_0010}, '0, $urandom);
    idle_steps(2);
    step(2'b00, 2'b00, '0, '0, 32'hDEAD_BEEF);
    check_eq("load_rdata", rdata_o, 32'hDEAD_BEEF);
    check_eq("load_rvalid", rvalid_o, 2'b01);
    idle_steps(2);
    step(2'b10, 2'b10, {32'h0000_0020, 32'h0}, {32'h0000_ABCD, 32'h0}, $urandom);
    check_eq("store_wdata", mem_wdata_o, 32'h0000_ABCD);
    idle_steps(LAT + 3);
    check_eq("store_keeps_rdata", rdata_o, 32'hDEAD_BEEF);
    step(2'b01, 2'b00, {32'h0, 32'h0000_0044}, '0, $urandom);
    idle_steps(1);
    busy_granted = 0;
    for (int i = 0; i < 20 && !busy_granted; i++) begin
      step(2'b10, 2'b00, {32'h0000_0088, 32'h0}, '0, $urandom);
      busy_granted = eg_last == 2'b10;
    end
    check_eq("busy_req_granted", busy_granted, 1'b1);
    idle_steps(LAT + 3);
    step(2'b01, 2'b00, {32'h0, 32'h0000_0030}, '0, $urandom);
    idle_steps(2);
    req_i = 2'b00;
    arst_ni = 1'b0;
    #1;
    check_eq("rst_gnt", gnt_o, 2'b00);
    check_eq("rst_rvalid", rvalid_o, 2'b00);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_mem_req", mem_req_o, 1'b0);
    check_eq("rst_mem_addr", mem_addr_o, '0);
    check_eq("rst_rdata", rdata_o, '0);
    model_reset();
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(2'b01, 2'b00, {32'h0, 32'h0000_0034}, '0, $urandom);
    idle_steps(LAT + 3);
    pend = '0; pwe = '0; pa = '0; pw = '0;
    repeat (1500) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(2) == 0) begin
          pend[p] = 1'b1;
          pwe[p] = 1'($urandom);
          pa[p*DW +: DW] = $urandom;
          pw[p*DW +: DW] = $urandom;
        end
      step(pend, pwe, pa, pw, $urandom);
      pend = pend & ~eg_last;
    end
    lreq1 = 2'b01;
    lreq15 = 2'b01;
    #1;
    check_eq("lat1_gnt", lgnt1, 2'b01);
    check_eq("lat15_gnt", lgnt15, 2'b01);
    n1 = 0;
    n15 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk_i);
      #1;
      lreq1 = 2'b00;
      lreq15 = 2'b00;
      if (lrv1 == 2'b01 && n1 == 0) n1 = n;
      if (lrv15 == 2'b01 && n15 == 0) n15 = n;
    end
    check_eq("lat1_rvalid_cycle", n1, 3);
    check_eq("lat15_rvalid_cycle", n15, 17);
    check_eq("lat15_rdata", lrd15, 32'h1111_000F);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
